// File: rtl/mismatch_stim_gen_if.sv
// ---------------------------------------------------------------------------
// mismatch_stim_gen_if
// Bundles the run enable, the mismatch-gain configuration handshake and the
// stimulus outputs of mismatch_stim_gen.
//   en        run enable, looked at only at slot start
//   cfg_vld   new gain offered            cfg_rdy  gain shadow register free
//   cfg_gr/gi signed Q1.15 gain (re/im)
//   clkdv     data clock, clk/8
//   rr/ri     signed QPSK reference       xr/xi    signed mismatched sample
// master: the side that drives enable/configuration and consumes stimulus.
// slave : the stimulus generator itself.
// ---------------------------------------------------------------------------
interface mismatch_stim_gen_if;
  logic               en;
  logic               cfg_vld;
  logic               cfg_rdy;
  logic signed [15:0] cfg_gr;
  logic signed [15:0] cfg_gi;
  logic               clkdv;
  logic signed [15:0] rr;
  logic signed [15:0] ri;
  logic signed [15:0] xr;
  logic signed [15:0] xi;

  modport master (
    output en, cfg_vld, cfg_gr, cfg_gi,
    input  cfg_rdy, clkdv, rr, ri, xr, xi
  );

  modport slave (
    input  en, cfg_vld, cfg_gr, cfg_gi,
    output cfg_rdy, clkdv, rr, ri, xr, xi
  );
endinterface

// File: rtl/mismatch_stim_gen.sv
// ---------------------------------------------------------------------------
// mismatch_stim_gen
// Stimulus source for the complex adaptive mismatch compensator. Each 8-clock
// slot draws one PRBS15-driven QPSK symbol (sr, si), multiplies it by the
// active complex gain on one shared 16x16 multiplier and presents both the
// clean symbol (rr/ri) and the mismatched one (xr/xi) for the whole next
// slot, together with the clk/8 data clock clkdv.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, clears all state
//   bus    mismatch_stim_gen_if.slave (en, cfg handshake, clkdv, rr/ri/xr/xi)
// ---------------------------------------------------------------------------
module mismatch_stim_gen #(
  parameter logic signed [15:0] AMP       = 16'sd23170,
  parameter logic        [14:0] LFSR_SEED = 15'h7FFF
) (
  input  logic               clk,
  input  logic               rst_n,
  mismatch_stim_gen_if.slave bus
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 1;

  localparam logic signed [DATA_W-1:0] NEG_AMP = -AMP;
  localparam logic signed [DATA_W-1:0] GAIN_ONE = 16'sh7FFF;
  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ACC_W'(-32768);

  // Q2.30 accumulator back to Q1.15: floor shift, then clamp.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> (DATA_W - 1);
    if (s > SAT_MAX)      return 16'sh7FFF;
    else if (s < SAT_MIN) return 16'sh8000;
    else                  return $signed(s[DATA_W-1:0]);
  endfunction

  logic        [2:0]         cnt;
  logic                      clkdv_q;
  logic        [14:0]        lfsr;
  logic signed [COEF_W-1:0]  gr_act, gi_act, gr_shd, gi_shd;
  logic                      pending;
  logic                      vld_p0;
  logic signed [DATA_W-1:0]  sr_p0, si_p0;
  logic signed [PROD_W-1:0]  prod_p1;
  logic signed [ACC_W-1:0]   acc_r_p2, acc_i_p2;
  logic signed [DATA_W-1:0]  rr_q, ri_q, xr_q, xi_q;

  logic                      slot_start;
  logic                      cfg_acc;
  logic signed [DATA_W-1:0]  mul_a;
  logic signed [COEF_W-1:0]  mul_b;
  logic signed [PROD_W-1:0]  mul_y;

  assign slot_start = (cnt == 3'd0);
  // The shadow register is free exactly when no transfer is pending.
  assign cfg_acc    = bus.cfg_vld & ~pending;

  // Operand schedule: cnt1 sr*gr, cnt2 si*gi, cnt3 sr*gi, cnt4 si*gr.
  assign mul_a = (cnt == 3'd1 || cnt == 3'd3) ? sr_p0 : si_p0;
  assign mul_b = (cnt == 3'd1 || cnt == 3'd4) ? gr_act : gi_act;
  assign mul_y = PROD_W'(mul_a) * PROD_W'(mul_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 3'd0;
      clkdv_q  <= 1'b0;
      lfsr     <= LFSR_SEED;
      gr_act   <= GAIN_ONE;
      gi_act   <= '0;
      gr_shd   <= GAIN_ONE;
      gi_shd   <= '0;
      pending  <= 1'b0;
      vld_p0   <= 1'b0;
      sr_p0    <= '0;
      si_p0    <= '0;
      prod_p1  <= '0;
      acc_r_p2 <= '0;
      acc_i_p2 <= '0;
      rr_q     <= '0;
      ri_q     <= '0;
      xr_q     <= '0;
      xi_q     <= '0;
    end else begin
      cnt     <= cnt + 3'd1;
      clkdv_q <= cnt[2];

      if (cfg_acc) begin
        gr_shd <= bus.cfg_gr;
        gi_shd <= bus.cfg_gi;
      end
      // An accept at slot start only arms the transfer for the next slot.
      if (cfg_acc)         pending <= 1'b1;
      else if (slot_start) pending <= 1'b0;

      // ---- stage p0: slot start, gain transfer and symbol draw ----
      if (slot_start) begin
        vld_p0 <= bus.en;
        if (pending) begin
          gr_act <= gr_shd;
          gi_act <= gi_shd;
        end
        if (bus.en) begin
          sr_p0 <= lfsr[14] ? NEG_AMP : AMP;
          si_p0 <= lfsr[13] ? NEG_AMP : AMP;
          // Two steps of x^15 + x^14 + 1 per symbol.
          lfsr  <= {lfsr[12:0], lfsr[14] ^ lfsr[13], lfsr[13] ^ lfsr[12]};
        end
      end

      // ---- stage p1/p2: shared multiplier, product then accumulate ----
      case (cnt)
        3'd1, 3'd3: prod_p1  <= mul_y;
        3'd2:       acc_r_p2 <= ACC_W'(prod_p1) - ACC_W'(mul_y);
        3'd4:       acc_i_p2 <= ACC_W'(prod_p1) + ACC_W'(mul_y);
        default:    ;
      endcase

      // ---- output stage: publish at the end of an enabled slot ----
      if (cnt == 3'd7 && vld_p0) begin
        rr_q <= sr_p0;
        ri_q <= si_p0;
        xr_q <= sat16(acc_r_p2);
        xi_q <= sat16(acc_i_p2);
      end
    end
  end

  assign bus.cfg_rdy = ~pending;
  assign bus.clkdv   = clkdv_q;
  assign bus.rr      = rr_q;
  assign bus.ri      = ri_q;
  assign bus.xr      = xr_q;
  assign bus.xi      = xi_q;

endmodule

// File: tb/tb_mismatch_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_mismatch_stim_gen
// Directed bench for mismatch_stim_gen. Symbol values follow the PRBS15 seed
// 7FFF: draws k0..k6 are (-,-), k7 is (-,+), k8 and k9 are (+,+).
// ---------------------------------------------------------------------------
module tb_mismatch_stim_gen;
  logic clk = 1'b0;
  logic rst_n;

  mismatch_stim_gen_if bus();

  mismatch_stim_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int er, input int ei,
                         input int exr, input int exi);
    chk({tag, ".rr"}, bus.rr, er);
    chk({tag, ".ri"}, bus.ri, ei);
    chk({tag, ".xr"}, bus.xr, exr);
    chk({tag, ".xi"}, bus.xi, exi);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  pat;
    logic [23:0] pat24;

    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.cfg_vld = 1'b0;
    bus.cfg_gr  = '0;
    bus.cfg_gi  = '0;
    repeat (3) @(negedge clk);
    chk_out("rst", 0, 0, 0, 0);
    chk("rst.clkdv", bus.clkdv, 0);
    chk("rst.cfg_rdy", bus.cfg_rdy, 1);
    rst_n = 1'b1;

    // slot 0: clkdv shape and first symbol through identity gain
    pat = '0;
    for (int k = 0; k < 8; k++) begin adv(1); pat[k] = bus.clkdv; end
    chk("clkdv.slot0", pat, 8'hF0);
    chk_out("k0", -23170, -23170, -23170, -23170);

    pat = '0;
    for (int k = 0; k < 8; k++) begin adv(1); pat[k] = bus.clkdv; end
    chk("clkdv.slot1", pat, 8'hF0);
    chk_out("k1", -23170, -23170, -23170, -23170);
    chk("lfsr.after_k1", dut.lfsr, 15'h7FF0);

    // gain A offered at cnt0 of slot 2, held while data switches to B
    bus.cfg_vld = 1'b1;
    bus.cfg_gr  = 16'sd16384;
    bus.cfg_gi  = 16'sd0;
    adv(1);
    chk("cfg.rdy_after_accept", bus.cfg_rdy, 0);
    bus.cfg_gr  = -16'sd32768;
    bus.cfg_gi  = -16'sd32768;
    adv(7);
    chk_out("k2_identity", -23170, -23170, -23170, -23170);
    chk("cfg.rdy_at_cnt0", bus.cfg_rdy, 0);
    adv(1);
    chk("cfg.rdy_after_transfer", bus.cfg_rdy, 1);
    adv(1);
    chk("cfg.rdy_after_second", bus.cfg_rdy, 0);
    bus.cfg_vld = 1'b0;
    adv(6);
    chk_out("k3_half_gain", -23170, -23170, -11585, -11585);
    adv(8);
    chk_out("k4_negfull", -23170, -23170, 0, 32767);

    // three disabled slots, with an en pulse in the middle of one of them
    bus.en = 1'b0;
    pat24  = '0;
    for (int k = 0; k < 24; k++) begin
      adv(1);
      pat24[k] = bus.clkdv;
      if (k == 10) bus.en = 1'b1;
      if (k == 14) bus.en = 1'b0;
      if (k % 8 == 7) chk_out("en_off_hold", -23170, -23170, 0, 32767);
    end
    chk("clkdv.en_off", pat24, 24'hF0F0F0);
    chk("lfsr.en_off", dut.lfsr, 15'h7C00);
    bus.en = 1'b1;

    adv(8);
    chk_out("k5_resume", -23170, -23170, 0, 32767);
    adv(8);
    chk_out("k6", -23170, -23170, 0, 32767);
    adv(8);
    chk_out("k7_xr_sat_pos", -23170, 23170, 32767, 0);

    // gain A accepted at cnt0 of k8's slot, takes effect one slot later
    chk("cfg.rdy_idle", bus.cfg_rdy, 1);
    bus.cfg_vld = 1'b1;
    bus.cfg_gr  = 16'sd16384;
    bus.cfg_gi  = 16'sd0;
    adv(1);
    bus.cfg_vld = 1'b0;
    adv(7);
    chk_out("k8_xi_sat_neg", 23170, 23170, 0, -32768);
    adv(8);
    chk_out("k9_half_pos", 23170, 23170, 11585, 11585);

    // leave a gain pending, then reset in the middle of the slot (cnt3)
    bus.cfg_vld = 1'b1;
    bus.cfg_gr  = -16'sd32768;
    bus.cfg_gi  = -16'sd32768;
    adv(1);
    bus.cfg_vld = 1'b0;
    chk("cfg.rdy_pending", bus.cfg_rdy, 0);
    adv(2);
    #2 rst_n = 1'b0;
    #1;
    chk_out("midrst", 0, 0, 0, 0);
    chk("midrst.clkdv", bus.clkdv, 0);
    chk("midrst.cfg_rdy", bus.cfg_rdy, 1);
    chk("midrst.lfsr", dut.lfsr, 15'h7FFF);
    @(negedge clk);
    rst_n = 1'b1;

    pat = '0;
    for (int k = 0; k < 8; k++) begin adv(1); pat[k] = bus.clkdv; end
    chk("clkdv.after_rst", pat, 8'hF0);
    chk_out("rst_k0_identity", -23170, -23170, -23170, -23170);
    adv(8);
    chk_out("rst_k1_identity", -23170, -23170, -23170, -23170);
    chk("lfsr.rst_k1", dut.lfsr, 15'h7FF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
